// File: rtl/booth_mult_pipe.sv
// booth_mult_pipe: 3-stage radix-8 Booth multiplier with valid/ready flow control.
// Define PIPE_TAG_EN to carry a sideband tag alongside each transaction.
module booth_mult_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   mplier,
    input  logic [WIDTH-1:0]   mcand,
    input  logic               is_signed,
`ifdef PIPE_TAG_EN
    input  logic [TAG_W-1:0]   in_tag,
    output logic [TAG_W-1:0]   out_tag,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);
    localparam int N  = ((WIDTH + 3) / 3) * 3;
    localparam int G  = N / 3;
    localparam int PW = WIDTH + 3;
    localparam int P2 = 2 * WIDTH;

    logic en, v1, v2, v3;
    logic [N:0] y;
    logic [PW-1:0] m1, m2, m3, m4;
    logic [G-1:0][PW-1:0] pp, s1_pp;
    logic [P2-1:0] cs_s, cs_c, s2_s, s2_c;

    assign en        = !v3 || out_ready;
    assign in_ready  = en;
    assign out_valid = v3;
    assign y  = {{(N-WIDTH){is_signed & mplier[WIDTH-1]}}, mplier, 1'b0};
    assign m1 = {{3{is_signed & mcand[WIDTH-1]}}, mcand};
    assign m2 = m1 << 1;
    assign m3 = m1 + m2;
    assign m4 = m1 << 2;

    // Digit magnitude is ceil(k/2) of the low three bits, inverted for negative digits.
    always_comb begin
        logic [3:0] g;
        logic [2:0] k;
        logic [3:0] mag;
        logic [PW-1:0] a;
        g   = '0;
        k   = '0;
        mag = '0;
        a   = '0;
        pp  = '0;
        for (int i = 0; i < G; i++) begin
            g   = y[3*i +: 4];
            k   = g[3] ? ~g[2:0] : g[2:0];
            mag = ({1'b0, k} + 4'd1) >> 1;
            a   = mag == 4'd4 ? m4 : mag == 4'd3 ? m3 : mag == 4'd2 ? m2 : mag == 4'd1 ? m1 : '0;
            pp[i] = g[3] ? -a : a;
        end
    end

    always_comb begin
        logic [P2-1:0] t, s, c;
        t    = '0;
        s    = '0;
        c    = '0;
        cs_s = '0;
        cs_c = '0;
        for (int i = 0; i < G; i++) begin
            t    = {{(P2-PW){s1_pp[i][PW-1]}}, s1_pp[i]} << (3*i);
            s    = cs_s ^ cs_c ^ t;
            c    = ((cs_s & cs_c) | (cs_s & t) | (cs_c & t)) << 1;
            cs_s = s;
            cs_c = c;
        end
    end

    // Product only loads from valid S2 data so bubbles leave the bus untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            s1_pp   <= '0;
            s2_s    <= '0;
            s2_c    <= '0;
            product <= '0;
        end else if (en) begin
            v1    <= in_valid;
            s1_pp <= pp;
            v2    <= v1;
            s2_s  <= cs_s;
            s2_c  <= cs_c;
            v3    <= v2;
            if (v2)
                product <= s2_s + s2_c;
        end
    end

`ifdef PIPE_TAG_EN
    logic [TAG_W-1:0] t1, t2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t1      <= '0;
            t2      <= '0;
            out_tag <= '0;
        end else if (en) begin
            t1 <= in_tag;
            t2 <= t1;
            if (v2)
                out_tag <= t2;
        end
    end
`endif
endmodule

// File: tb/tb_booth_mult_pipe.sv
// tb_booth_mult_pipe: directed and random checks of booth_mult_pipe against a behavioural product model.
module tb_booth_mult_pipe;
    localparam int W = 32;
`ifdef PIPE_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b1, is_signed = 1'b0;
    logic in_ready, out_valid;
    logic [W-1:0] mplier = '0, mcand = '0;
    logic [3:0] in_tag = '0, out_tag;
    logic [2*W-1:0] product;
    int checks = 0, failures = 0;
    logic [67:0] q[$];
    logic stall_prev = 1'b0;
    logic [63:0] held_p;
    logic [3:0] held_t;

    booth_mult_pipe #(.WIDTH(W), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mplier(mplier), .mcand(mcand), .is_signed(is_signed),
`ifdef PIPE_TAG_EN
        .in_tag(in_tag), .out_tag(out_tag),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .product(product)
    );
`ifndef PIPE_TAG_EN
    assign out_tag = '0;
`endif

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb;
        sa = s ? {{32{a[31]}}, a} : {32'b0, a};
        sb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return sa * sb;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s, input logic [3:0] t);
        in_valid  = v;
        mplier    = a;
        mcand     = b;
        is_signed = s;
        in_tag    = t;
    endtask

    // Scoreboard: push at accept, pop at drain, check hold while stalled.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_product", product, held_p);
                check("hold_tag", {60'b0, out_tag}, {60'b0, held_t});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", {63'b0, out_valid}, 64'd0);
                end else begin
                    logic [67:0] e;
                    e = q.pop_front();
                    check("sb_product", product, e[63:0]);
                    check("sb_tag", {60'b0, out_tag}, {60'b0, e[67:64]});
                end
            end
            if (in_valid && in_ready)
                q.push_back({TAG_EN ? in_tag : 4'h0, model(mplier, mcand, is_signed)});
            stall_prev = out_valid && !out_ready;
            held_p     = product;
            held_t     = out_tag;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst = 1'b1;
        tick();
        tick();
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_out_tag", {60'b0, out_tag}, 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        rst = 1'b0;
        drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 4'd5);
        #1 check("first_accept_ready", {63'b0, in_ready}, 64'd1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 4'd0);
        check("lat_edge1", {63'b0, out_valid}, 64'd0);
        tick();
        check("lat_edge2", {63'b0, out_valid}, 64'd0);
        tick();
        check("lat_edge3", {63'b0, out_valid}, 64'd1);
        check("signed_m1xm1", product, 64'h0000000000000001);
        check("lat_tag", {60'b0, out_tag}, TAG_EN ? 64'd5 : 64'd0);
        drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'd6);
        tick();
        drive(1'b1, 32'h80000000, 32'h80000000, 1'b1, 4'd7);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 4'd0);
        tick();
        check("unsigned_ffxff", product, 64'hFFFFFFFE00000001);
        tick();
        check("signed_minxmin", product, 64'h4000000000000000);
        tick();
        tick();
        // back-to-back with a two-cycle output stall
        drive(1'b1, 32'd3, 32'd5, 1'b0, 4'd1);
        tick();
        drive(1'b1, 32'hFFFFFFFD, 32'd7, 1'b1, 4'd2);
        tick();
        drive(1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 4'd3);
        tick();
        drive(1'b1, 32'h7FFFFFFF, 32'h80000000, 1'b1, 4'd4);
        out_ready = 1'b0;
        tick();
        check("stall1_in_ready", {63'b0, in_ready}, 64'd0);
        check("stall1_out_valid", {63'b0, out_valid}, 64'd1);
        tick();
        check("stall2_in_ready", {63'b0, in_ready}, 64'd0);
        check("stall2_product", product, model(32'd3, 32'd5, 1'b0));
        out_ready = 1'b1;
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 4'd0);
        repeat (5) tick();
        check("b2b_drained", q.size(), 64'd0);
        // reset with two transactions in flight
        drive(1'b1, 32'd11, 32'd13, 1'b0, 4'd8);
        tick();
        drive(1'b1, 32'hFFFFFF00, 32'd9, 1'b1, 4'd9);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 4'd0);
        rst = 1'b1;
        q.delete();
        #1;
        check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        check("midrst_in_ready", {63'b0, in_ready}, 64'd1);
        check("midrst_product", product, 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("postrst_out_valid", {63'b0, out_valid}, 64'd0);
            check("postrst_product", product, 64'd0);
        end
        // random traffic, mixed modes, random backpressure
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a, b;
            int sa, sb;
            sa = $urandom_range(0, 7);
            sb = $urandom_range(0, 7);
            a = sa == 0 ? 32'h80000000 : sa == 1 ? 32'hFFFFFFFF : sa == 2 ? 32'h0 : $urandom;
            b = sb == 0 ? 32'h80000000 : sb == 1 ? 32'hFFFFFFFF : sb == 2 ? 32'h7FFFFFFF : $urandom;
            drive($urandom_range(0, 3) != 0, a, b, 1'($urandom_range(0, 1)), 4'($urandom));
            out_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 4'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++)
            tick();
        tick();
        check("random_drained", q.size(), 64'd0);
        check("final_out_valid", {63'b0, out_valid}, 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
